// File: rtl/rf_write_arbiter_if.sv
// Register-file write-port bundle: two write requesters in, one registered
// register-file write port plus debug counters out.
interface rf_write_arbiter_if #(
    parameter int XLEN = 32
);
    logic            a_valid;
    logic            a_ready;
    logic [4:0]      a_rd;
    logic [XLEN-1:0] a_data;
    logic            b_valid;
    logic            b_ready;
    logic [4:0]      b_rd;
    logic [XLEN-1:0] b_data;
    logic [4:0]      rf_rd;
    logic            rf_we;
    logic [XLEN-1:0] rf_data;
    logic [3:0]      starve_cnt;
    logic [15:0]     forced_grants;

    modport slave (
        input  a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        output a_ready, b_ready, rf_rd, rf_we, rf_data, starve_cnt, forced_grants
    );

    modport master (
        output a_valid, a_rd, a_data, b_valid, b_rd, b_data,
        input  a_ready, b_ready, rf_rd, rf_we, rf_data, starve_cnt, forced_grants
    );
endinterface

// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter: fixed priority to A, with forced B
// grants after STARVE_LIMIT waits. Optional same-rd squash: RF_ARB_WAW_SQUASH_EN.
module rf_write_arbiter #(
    parameter int XLEN         = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    rf_write_arbiter_if.slave   bus
);
    localparam logic [3:0]  LIMIT_C = 4'(STARVE_LIMIT);
    localparam logic [15:0] FG_MAX  = 16'hFFFF;

    logic [4:0]      r_rf_rd;
    logic            r_rf_we;
    logic [XLEN-1:0] r_rf_data;
    logic [3:0]      r_starve_cnt;
    logic [15:0]     r_forced_grants;

    logic            w_force_b;
    logic            w_squash;
    logic            w_a_ready;
    logic            w_b_ready;
    logic            w_a_xfer;
    logic            w_b_xfer;
    logic            w_issue;
    logic [4:0]      w_issue_rd;
    logic [XLEN-1:0] w_issue_data;

    // Grant decision and selection of the payload that reaches the write port
    always_comb begin
        w_force_b    = bus.b_valid && (r_starve_cnt == LIMIT_C);
`ifdef RF_ARB_WAW_SQUASH_EN
        w_squash     = bus.a_valid && bus.b_valid && (bus.a_rd == bus.b_rd) &&
                       (bus.a_rd != 5'd0) && !w_force_b;
`else
        w_squash     = 1'b0;
`endif
        w_a_ready    = 1'b0;
        w_b_ready    = 1'b0;
        w_issue_rd   = bus.a_rd;
        w_issue_data = bus.a_data;

        if (!rst) begin
            w_a_ready = 1'b0;
            w_b_ready = 1'b0;
        end else if (w_force_b) begin
            w_a_ready = 1'b0;
            w_b_ready = 1'b1;
        end else if (w_squash) begin
            // B's result is older and would be overwritten by A anyway
            w_a_ready = 1'b1;
            w_b_ready = 1'b1;
        end else if (bus.a_valid) begin
            w_a_ready = 1'b1;
            w_b_ready = 1'b0;
        end else begin
            w_a_ready = 1'b1;
            w_b_ready = 1'b1;
        end

        w_a_xfer = bus.a_valid && w_a_ready;
        w_b_xfer = bus.b_valid && w_b_ready;
        w_issue  = w_a_xfer || w_b_xfer;

        if (w_a_xfer) begin
            w_issue_rd   = bus.a_rd;
            w_issue_data = bus.a_data;
        end else begin
            w_issue_rd   = bus.b_rd;
            w_issue_data = bus.b_data;
        end
    end

    // Registered register-file write port; x0 writes are consumed without enable
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rf_rd   <= 5'd0;
            r_rf_we   <= 1'b0;
            r_rf_data <= '0;
        end else if (w_issue) begin
            r_rf_rd   <= w_issue_rd;
            r_rf_we   <= (w_issue_rd != 5'd0);
            r_rf_data <= w_issue_data;
        end else begin
            r_rf_we   <= 1'b0;
        end
    end

    // B wait counter and saturating forced-grant counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve_cnt    <= 4'd0;
            r_forced_grants <= 16'd0;
        end else begin
            if (w_b_xfer || !bus.b_valid) begin
                r_starve_cnt <= 4'd0;
            end else if (r_starve_cnt < LIMIT_C) begin
                r_starve_cnt <= r_starve_cnt + 4'd1;
            end else begin
                r_starve_cnt <= r_starve_cnt;
            end

            if (w_force_b && (r_forced_grants != FG_MAX)) begin
                r_forced_grants <= r_forced_grants + 16'd1;
            end else begin
                r_forced_grants <= r_forced_grants;
            end
        end
    end

    assign bus.a_ready       = w_a_ready;
    assign bus.b_ready       = w_b_ready;
    assign bus.rf_rd         = r_rf_rd;
    assign bus.rf_we         = r_rf_we;
    assign bus.rf_data       = r_rf_data;
    assign bus.starve_cnt    = r_starve_cnt;
    assign bus.forced_grants = r_forced_grants;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter (STARVE_LIMIT=4); same-rd expectations
// follow RF_ARB_WAW_SQUASH_EN.
module tb_rf_write_arbiter;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    rf_write_arbiter_if #(.XLEN(XLEN)) bus_if ();

    rf_write_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus_if.a_valid = 1'b0; bus_if.a_rd = 5'd0; bus_if.a_data = 32'h0;
        bus_if.b_valid = 1'b0; bus_if.b_rd = 5'd0; bus_if.b_data = 32'h0;
        rst = 1'b0;
        tick(); tick();
        bus_if.a_valid = 1'b1; bus_if.a_rd = 5'd5;
        #1;
        chk("rst_rf_we",    32'(bus_if.rf_we), 32'h0);
        chk("rst_rf_rd",    32'(bus_if.rf_rd), 32'h0);
        chk("rst_rf_data",  bus_if.rf_data, 32'h0);
        chk("rst_starve",   32'(bus_if.starve_cnt), 32'h0);
        chk("rst_forced",   32'(bus_if.forced_grants), 32'h0);
        chk("rst_a_ready",  32'(bus_if.a_ready), 32'h0);
        chk("rst_b_ready",  32'(bus_if.b_ready), 32'h0);
        bus_if.a_valid = 1'b0;
        tick();
        rst = 1'b1;

        // single A write
        bus_if.a_valid = 1'b1; bus_if.a_rd = 5'd3; bus_if.a_data = 32'hDEADBEEF;
        #1;
        chk("a_single_a_ready", 32'(bus_if.a_ready), 32'h1);
        chk("a_single_b_ready", 32'(bus_if.b_ready), 32'h0);
        tick();
        chk("a_single_we",   32'(bus_if.rf_we), 32'h1);
        chk("a_single_rd",   32'(bus_if.rf_rd), 32'h3);
        chk("a_single_data", bus_if.rf_data, 32'hDEADBEEF);

        // reset asserted mid-transfer drops the write immediately
        bus_if.a_rd = 5'd5; bus_if.a_data = 32'h55;
        tick();
        chk("pre_rst_rd", 32'(bus_if.rf_rd), 32'h5);
        chk("pre_rst_we", 32'(bus_if.rf_we), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rst_we",      32'(bus_if.rf_we), 32'h0);
        chk("mid_rst_rd",      32'(bus_if.rf_rd), 32'h0);
        chk("mid_rst_data",    bus_if.rf_data, 32'h0);
        chk("mid_rst_a_ready", 32'(bus_if.a_ready), 32'h0);
        tick();
        chk("held_rst_we", 32'(bus_if.rf_we), 32'h0);
        rst = 1'b1;
        #1;
        chk("post_rst_a_ready", 32'(bus_if.a_ready), 32'h1);
        tick();
        chk("post_rst_we",   32'(bus_if.rf_we), 32'h1);
        chk("post_rst_rd",   32'(bus_if.rf_rd), 32'h5);
        chk("post_rst_data", bus_if.rf_data, 32'h55);
        bus_if.a_valid = 1'b0;
        tick();
        chk("idle_we",      32'(bus_if.rf_we), 32'h0);
        chk("idle_rd_hold", 32'(bus_if.rf_rd), 32'h5);

        // B write to x0 is consumed without a write enable
        bus_if.b_valid = 1'b1; bus_if.b_rd = 5'd0; bus_if.b_data = 32'h1234;
        #1;
        chk("x0_b_ready", 32'(bus_if.b_ready), 32'h1);
        chk("x0_a_ready", 32'(bus_if.a_ready), 32'h1);
        tick();
        chk("x0_we",   32'(bus_if.rf_we), 32'h0);
        chk("x0_rd",   32'(bus_if.rf_rd), 32'h0);
        chk("x0_data", bus_if.rf_data, 32'h1234);

        // starvation: A streams rd=1..4 while B waits, then B is forced
        bus_if.b_rd = 5'd7; bus_if.b_data = 32'hCAFE;
        bus_if.a_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus_if.a_rd = 5'(i + 1); bus_if.a_data = 32'h100 + 32'(i);
            #1;
            chk("starve_b_ready", 32'(bus_if.b_ready), 32'h0);
            chk("starve_a_ready", 32'(bus_if.a_ready), 32'h1);
            chk("starve_cnt",     32'(bus_if.starve_cnt), 32'(i));
            tick();
            chk("starve_a_rd",   32'(bus_if.rf_rd), 32'(i + 1));
            chk("starve_a_data", bus_if.rf_data, 32'h100 + 32'(i));
        end
        bus_if.a_rd = 5'd5; bus_if.a_data = 32'h105;
        #1;
        chk("force_cnt",     32'(bus_if.starve_cnt), 32'h4);
        chk("force_a_ready", 32'(bus_if.a_ready), 32'h0);
        chk("force_b_ready", 32'(bus_if.b_ready), 32'h1);
        tick();
        chk("force_rd",     32'(bus_if.rf_rd), 32'h7);
        chk("force_data",   bus_if.rf_data, 32'hCAFE);
        chk("force_we",     32'(bus_if.rf_we), 32'h1);
        chk("force_count",  32'(bus_if.forced_grants), 32'h1);
        chk("force_clear",  32'(bus_if.starve_cnt), 32'h0);
        bus_if.b_valid = 1'b0;
        #1;
        chk("after_force_a_ready", 32'(bus_if.a_ready), 32'h1);
        tick();
        chk("after_force_rd", 32'(bus_if.rf_rd), 32'h5);

        // idle B: two denied cycles then withdraw
        bus_if.b_valid = 1'b1; bus_if.b_rd = 5'd8; bus_if.b_data = 32'h88;
        tick();
        tick();
        chk("idleb_cnt2", 32'(bus_if.starve_cnt), 32'h2);
        bus_if.b_valid = 1'b0;
        tick();
        chk("idleb_cnt0", 32'(bus_if.starve_cnt), 32'h0);
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("idleb_a_ready", 32'(bus_if.a_ready), 32'h1);
            tick();
        end
        chk("idleb_forced", 32'(bus_if.forced_grants), 32'h1);
        bus_if.a_valid = 1'b0;
        tick();

        // same destination from both requesters
        bus_if.a_valid = 1'b1; bus_if.a_rd = 5'd9; bus_if.a_data = 32'hA;
        bus_if.b_valid = 1'b1; bus_if.b_rd = 5'd9; bus_if.b_data = 32'hB;
        #1;
`ifdef RF_ARB_WAW_SQUASH_EN
        chk("waw_a_ready", 32'(bus_if.a_ready), 32'h1);
        chk("waw_b_ready", 32'(bus_if.b_ready), 32'h1);
        tick();
        chk("waw_rd",   32'(bus_if.rf_rd), 32'h9);
        chk("waw_data", bus_if.rf_data, 32'hA);
        chk("waw_we",   32'(bus_if.rf_we), 32'h1);
        chk("waw_cnt",  32'(bus_if.starve_cnt), 32'h0);
        bus_if.a_valid = 1'b0; bus_if.b_valid = 1'b0;
        tick();
        chk("waw_single_we", 32'(bus_if.rf_we), 32'h0);
`else
        chk("waw_a_ready", 32'(bus_if.a_ready), 32'h1);
        chk("waw_b_ready", 32'(bus_if.b_ready), 32'h0);
        tick();
        chk("waw_a_rd",   32'(bus_if.rf_rd), 32'h9);
        chk("waw_a_data", bus_if.rf_data, 32'hA);
        chk("waw_a_we",   32'(bus_if.rf_we), 32'h1);
        bus_if.a_valid = 1'b0;
        #1;
        chk("waw_b_ready2", 32'(bus_if.b_ready), 32'h1);
        tick();
        chk("waw_b_rd",   32'(bus_if.rf_rd), 32'h9);
        chk("waw_b_data", bus_if.rf_data, 32'hB);
        chk("waw_b_we",   32'(bus_if.rf_we), 32'h1);
        bus_if.b_valid = 1'b0;
        tick();
        chk("waw_done_we", 32'(bus_if.rf_we), 32'h0);
`endif
        chk("final_forced", 32'(bus_if.forced_grants), 32'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
